ro_sensor_scheduler: RTL

- Sequences a bank of NUM_RO ring-oscillator sensors. Each sensor is a chain of combinational-loop inverter stages that the design instantiates elsewhere.
- Per measurement:
  - enables exactly one oscillator;
  - waits a settle period;
  - counts its rising edges over a programmable window of clock cycles;
  - reports the count.
- Supports single-shot measurement of one channel, or round-robin scan of all channels.
- Sits between the hwdbg sensor bank and the debugger register interface.

---
 rtl/hwdbg_sensor_pkg.sv | 17 +
 rtl/ro_edge_counter.sv | 60 ++++++
 rtl/ro_sensor_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hwdbg_sensor_pkg.sv
// Shared types and constants for the ring-oscillator sensor scheduler.
package hwdbg_sensor_pkg;

    // Width of a channel index (supports up to 16 oscillators).
    localparam int unsigned ChanW = 4;

    // Shortest settle period that still flushes the synchronizer after a channel switch.
    localparam int unsigned MinSettle = 3;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDone
    } sensor_state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one oscillator output, detects rising edges and counts them with saturation.
module ro_edge_counter #(
    parameter int unsigned CountW = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ro_i,
    input  logic              clear_i,
    input  logic              count_en_i,
    output logic [CountW-1:0] count_next_o,
    output logic              overflow_next_o
);

    localparam logic [CountW-1:0] CountMax = '1;

    logic              sync1_q, sync2_q, sync3_q;
    logic              rise;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;

    assign rise = sync2_q & ~sync3_q;

    // Next count: clear wins, otherwise saturating increment on a detected edge.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (count_en_i && rise) begin
            if (count_q == CountMax) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CountW'(1);
            end
        end
    end

    // Synchronizer chain, edge-detect flop and counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= ro_i;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // The scheduler captures results on the edge that enters DONE, so it needs the next value.
    assign count_next_o    = count_d;
    assign overflow_next_o = overflow_d;

endmodule

// File: rtl/ro_sensor_scheduler.sv
// Sequences a bank of ring oscillators: enable one, settle, count edges over a window, report.
module ro_sensor_scheduler
    import hwdbg_sensor_pkg::*;
#(
    parameter int unsigned NUM_RO        = 4,
    parameter int unsigned COUNT_W       = 20,
    parameter int unsigned WINDOW_W      = 16,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_start,
    input  logic                io_abort,
    input  logic                io_scan,
    input  logic [ChanW-1:0]    io_channel,
    input  logic [WINDOW_W-1:0] io_window,
    input  logic [NUM_RO-1:0]   ro_in,
    output logic [NUM_RO-1:0]   ro_enable,
    output logic                io_busy,
    output logic                io_done,
    output logic [COUNT_W-1:0]  io_count,
    output logic [ChanW-1:0]    io_count_channel,
    output logic                io_overflow,
    output logic                io_error
);

    localparam int unsigned SettleLoadI =
        (SETTLE_CYCLES < MinSettle) ? MinSettle - 1 : SETTLE_CYCLES - 1;
    localparam int unsigned SettleW = $clog2(SettleLoadI + 1);
    localparam int unsigned TimerW  = (WINDOW_W > SettleW) ? WINDOW_W : SettleW;
    localparam logic [TimerW-1:0] SettleLoad = TimerW'(SettleLoadI);
    localparam logic [ChanW-1:0]  LastCh     = ChanW'(NUM_RO - 1);

    sensor_state_e       state_q, state_d;
    logic                scan_q, scan_d;
    logic [ChanW-1:0]    ch_q, ch_d;
    logic [WINDOW_W-1:0] window_q, window_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                error_q, error_d;
    logic [NUM_RO-1:0]   enable_q, enable_d;
    logic                done_q;
    logic [COUNT_W-1:0]  count_q;
    logic [ChanW-1:0]    count_ch_q;
    logic                overflow_q;

    logic                cnt_clear, cnt_en, load_result, ro_sel;
    logic [COUNT_W-1:0]  cnt_next;
    logic                cnt_ovf_next;

    // Select the oscillator of the latched channel; invalid channels read as 0.
    always_comb begin
        ro_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (ch_q == ChanW'(i)) ro_sel = ro_in[i];
        end
    end

    ro_edge_counter #(
        .CountW (COUNT_W)
    ) u_edge_counter (
        .clk_i           (clock),
        .rst_i           (reset),
        .ro_i            (ro_sel),
        .clear_i         (cnt_clear),
        .count_en_i      (cnt_en),
        .count_next_o    (cnt_next),
        .overflow_next_o (cnt_ovf_next)
    );

    // Next-state logic for the measurement sequence; abort overrides every other transition.
    always_comb begin
        state_d   = state_q;
        scan_d    = scan_q;
        ch_d      = ch_q;
        window_d  = window_q;
        timer_d   = timer_q;
        error_d   = error_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (io_start) begin
                    scan_d    = io_scan;
                    ch_d      = io_scan ? '0 : io_channel;
                    window_d  = io_window;
                    cnt_clear = 1'b1;
                    if (!io_scan && (io_channel > LastCh)) begin
                        state_d = StDone;
                        error_d = 1'b1;
                    end else begin
                        state_d = StSettle;
                        error_d = 1'b0;
                        timer_d = SettleLoad;
                    end
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    if (window_q == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StMeasure;
                        timer_d = TimerW'(window_q) - TimerW'(1);
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StMeasure: begin
                cnt_en = 1'b1;
                if (timer_q == '0) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StDone: begin
                if (scan_q && (ch_q < LastCh)) begin
                    ch_d      = ch_q + ChanW'(1);
                    cnt_clear = 1'b1;
                    state_d   = StSettle;
                    timer_d   = SettleLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (io_abort && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_en  = 1'b0;
        end
    end

    assign load_result = (state_d == StDone);

    // Enables are decoded from next state and registered so the oscillators see clean edges.
    always_comb begin
        enable_d = '0;
        for (int unsigned i = 0; i < NUM_RO; i++) begin
            enable_d[i] = ((state_d == StSettle) || (state_d == StMeasure)) && (ch_d == ChanW'(i));
        end
    end

    // State, request latches and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            scan_q     <= 1'b0;
            ch_q       <= '0;
            window_q   <= '0;
            timer_q    <= '0;
            error_q    <= 1'b0;
            enable_q   <= '0;
            done_q     <= 1'b0;
            count_q    <= '0;
            count_ch_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            scan_q   <= scan_d;
            ch_q     <= ch_d;
            window_q <= window_d;
            timer_q  <= timer_d;
            error_q  <= error_d;
            enable_q <= enable_d;
            done_q   <= load_result;
            if (load_result) begin
                count_q    <= cnt_next;
                count_ch_q <= ch_d;
                overflow_q <= cnt_ovf_next;
            end
        end
    end

    assign ro_enable        = enable_q;
    assign io_busy          = (state_q != StIdle);
    assign io_done          = done_q;
    assign io_count         = count_q;
    assign io_count_channel = count_ch_q;
    assign io_overflow      = overflow_q;
    assign io_error         = error_q;

endmodule
